complex_vector_op_sequencer: RTL

- Operand sequencer that sits directly upstream of the complex adder/subtractor stage (64-bit {real[63:32], imj[31:0]} single-precision pairs).
- On a go pulse it streams LEN element pairs from two operand banks (A bank, B bank) into the adder, one element per cycle, with a start pulse per element.
- It takes the adder's finish_dash/result back and writes results sequentially into a result bank.
- It owns the adder's op and iteration_reinitialization controls.

---
 rtl/complex_vector_op_sequencer_if.sv | 45 ++++
 rtl/complex_vector_op_sequencer.sv | 117 +++++++++++
 2 files changed

// File: rtl/complex_vector_op_sequencer_if.sv
// Bundles the control, bank-read, adder and result-write signals of the operand sequencer.
interface complex_vector_op_sequencer_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 64
);
  // Control
  logic              go;
  logic [ADDR_W:0]   len;
  logic              op_sel;
  logic              hold;
  logic              busy;
  logic              done;
  logic              err_unexpected;
  // Operand banks
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] a_rd_data;
  logic [DATA_W-1:0] b_rd_data;
  // Adder
  logic [DATA_W-1:0] add_a;
  logic [DATA_W-1:0] add_b;
  logic              add_start;
  logic              add_op;
  logic              add_reinit;
  logic              add_finish_dash;
  logic [DATA_W-1:0] add_result;
  // Result bank
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Environment side: controller, banks and adder
  modport master (
    output go, len, op_sel, hold, a_rd_data, b_rd_data, add_finish_dash, add_result,
    input  busy, done, err_unexpected, rd_en, rd_addr, add_a, add_b, add_start, add_op,
    input  add_reinit, wr_en, wr_addr, wr_data
  );

  // Sequencer side
  modport slave (
    input  go, len, op_sel, hold, a_rd_data, b_rd_data, add_finish_dash, add_result,
    output busy, done, err_unexpected, rd_en, rd_addr, add_a, add_b, add_start, add_op,
    output add_reinit, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/complex_vector_op_sequencer.sv
// Streams LEN operand pairs from the A/B banks into the complex adder and writes the
// adder results back sequentially into the result bank.
module complex_vector_op_sequencer #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 64
) (
  input logic                         clk,
  input logic                         rst,
  complex_vector_op_sequencer_if.slave io
);
  localparam int unsigned   CntW   = ADDR_W + 1;
  localparam logic [CntW-1:0] MaxLen = CntW'(2 ** ADDR_W);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic [CntW-1:0]   r_len;
  logic [CntW-1:0]   r_rd_cnt;
  logic [CntW-1:0]   r_wr_cnt;
  logic [CntW-1:0]   r_outst;
  logic              r_op;
  logic              r_start;
  logic              r_err;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;

  logic              w_go_acc;
  logic              w_rd_fire;
  logic              w_wr_fire;
  logic              w_unexp;
  logic              w_active;
  logic [CntW-1:0]   w_len_sat;

  assign w_go_acc  = (r_state == StIdle) && io.go;
  assign w_len_sat = (io.len > MaxLen) ? MaxLen : io.len;
  assign w_rd_fire = (r_state == StIssue) && !io.hold && (r_rd_cnt != r_len);
  assign w_wr_fire = io.add_finish_dash && (r_outst != '0);
  assign w_unexp   = io.add_finish_dash && (r_outst == '0);
  assign w_active  = (r_state == StIssue) || (r_state == StDrain);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  // Next-state: leave ISSUE on the final read, leave DRAIN on the final write
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_go_acc) w_state_next = (w_len_sat == '0) ? StDone : StIssue;
      StIssue: if (w_rd_fire && (r_rd_cnt + CntW'(1) == r_len)) w_state_next = StDrain;
      StDrain: if (w_wr_fire && (r_wr_cnt + CntW'(1) == r_len)) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Run parameters, counters, outstanding count and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len    <= '0;
      r_op     <= 1'b0;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
      r_outst  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_go_acc) begin
        r_len    <= w_len_sat;
        r_op     <= io.op_sel;
        r_rd_cnt <= '0;
        r_wr_cnt <= '0;
      end else begin
        if (w_rd_fire) r_rd_cnt <= r_rd_cnt + CntW'(1);
        if (w_wr_fire) r_wr_cnt <= r_wr_cnt + CntW'(1);
      end
      r_outst <= r_outst + CntW'(r_start) - CntW'(w_wr_fire);
      if (w_unexp)       r_err <= 1'b1;
      else if (w_go_acc) r_err <= 1'b0;
    end
  end

  // Issue pipeline: start follows the read by one cycle, operands held between starts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_start <= w_rd_fire;
      if (r_start) begin
        r_a <= io.a_rd_data;
        r_b <= io.b_rd_data;
      end
    end
  end

  // Bank data is already registered in the banks, so it reaches the adder in the start cycle
  assign io.add_a      = r_start ? io.a_rd_data : r_a;
  assign io.add_b      = r_start ? io.b_rd_data : r_b;
  assign io.add_start  = r_start;
  assign io.add_op     = w_active && r_op;
  assign io.add_reinit = (r_state != StIdle);

  assign io.rd_en   = w_rd_fire;
  assign io.rd_addr = w_rd_fire ? r_rd_cnt[ADDR_W-1:0] : '0;

  assign io.wr_en   = w_wr_fire;
  assign io.wr_addr = w_wr_fire ? r_wr_cnt[ADDR_W-1:0] : '0;
  assign io.wr_data = w_wr_fire ? io.add_result : '0;

  assign io.busy           = w_active;
  assign io.done           = (r_state == StDone);
  assign io.err_unexpected = r_err;
endmodule
